// File: rtl/pipeline_types.sv
// Types and stage indices shared by the in-order pipeline hazard logic.
package pipeline_types;

  typedef enum logic [1:0] {
    FW_NONE = 2'd0,
    FW_EX   = 2'd1,
    FW_ME   = 2'd2
  } fw_sel_t;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_DRAIN = 2'd1,
    HZ_HALT  = 2'd2
  } hz_state_t;

  localparam int STG_IF = 0;
  localparam int STG_ID = 1;
  localparam int STG_EX = 2;
  localparam int STG_ME = 3;

endpackage

// File: rtl/hz_scoreboard_regs.sv
// Pending-register bitmap and outstanding long-latency op counter.
// A set and a clear of the same register in one cycle leaves the bit set.
module hz_scoreboard_regs #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = $clog2(NUM_REGS),
  parameter int MAX_LONG = 4,
  parameter int LCNT_W   = $clog2(MAX_LONG + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [REG_AW-1:0]   set_idx,
  input  logic                clr_req,
  input  logic [REG_AW-1:0]   clr_idx,
  output logic [NUM_REGS-1:0] pending,
  output logic [LCNT_W-1:0]   long_cnt
);

  logic                clr_en;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // A completion for a register that is not pending is ignored entirely.
  assign clr_en = clr_req & pending[clr_idx];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
  end

  // NOTE: the bitmap is a small flop array, so it is reset like any other state;
  // sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      long_cnt <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      case ({set_en, clr_en})
        2'b10:   long_cnt <= long_cnt + LCNT_W'(1);
        2'b01:   long_cnt <= long_cnt - LCNT_W'(1);
        default: long_cnt <= long_cnt;
      endcase
    end
  end

  a_done_pending: assert property (@(posedge clk) disable iff (!rst_n)
    clr_req |-> pending[clr_idx])
    else $error("long-op completion for idle register %0d", clr_idx);

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard unit: RAW/WAW/structural stalls, forwarding selects,
// branch flush latching across memory stalls and a debug drain/halt FSM.
module hazard_scoreboard
  import pipeline_types::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int REG_AW       = $clog2(NUM_REGS),
  parameter int NUM_STAGES   = 4,
  parameter int FRONT_STAGES = 2,
  parameter int MAX_LONG     = 4,
  parameter int CNT_W        = 32
) (
  input  logic                           iClk,
  input  logic                           nRst,
  input  logic                           iIssue_valid,
  input  logic [REG_AW-1:0]              iIssue_rs1,
  input  logic [REG_AW-1:0]              iIssue_rs2,
  input  logic [REG_AW-1:0]              iIssue_rd,
  input  logic                           iIssue_long,
  input  logic [REG_AW-1:0]              iEx_rd,
  input  logic                           iEx_wen,
  input  logic [REG_AW-1:0]              iMe_rd,
  input  logic                           iMe_wen,
  input  logic                           iLong_done,
  input  logic [REG_AW-1:0]              iLong_rd,
  input  logic                           iBrTrue,
  input  logic                           iStall_IF,
  input  logic                           iStall_ME,
  input  logic                           iStall_dbg,
  output logic [NUM_STAGES-1:0]          oStall,
  output logic [NUM_STAGES-1:0]          oFlush,
  output fw_sel_t                        oFwS1_sel,
  output fw_sel_t                        oFwS2_sel,
  output logic [NUM_REGS-1:0]            oPending,
  output logic [$clog2(MAX_LONG+1)-1:0]  oLongCnt,
  output logic                           oHalted,
  output logic [CNT_W-1:0]               oStallCycles
);

  localparam int LCNT_W = $clog2(MAX_LONG + 1);

  hz_state_t             state, state_nxt;
  logic                  br_pend;
  logic                  mem_stall, hz_stall, br_flush, accept, set_en;
  logic                  raw1, raw2, waw, strc;
  logic [NUM_STAGES-1:0] stall_v, flush_v;

  function automatic fw_sel_t fw_pick(input logic [REG_AW-1:0] rs,
                                      input logic ex_wen, input logic [REG_AW-1:0] ex_rd,
                                      input logic me_wen, input logic [REG_AW-1:0] me_rd);
    if (rs == '0)                  return FW_NONE;
    if (ex_wen && (rs == ex_rd))   return FW_EX;
    if (me_wen && (rs == me_rd))   return FW_ME;
    return FW_NONE;
  endfunction

  always_comb begin
    oFwS1_sel = FW_NONE;
    oFwS2_sel = FW_NONE;
    if (nRst) begin
      oFwS1_sel = fw_pick(iIssue_rs1, iEx_wen, iEx_rd, iMe_wen, iMe_rd);
      oFwS2_sel = fw_pick(iIssue_rs2, iEx_wen, iEx_rd, iMe_wen, iMe_rd);
    end
  end

  // A pending source is released early when its producer completes this cycle
  // and the value is picked up from the ME forwarding path.
  assign raw1 = (iIssue_rs1 != '0) && oPending[iIssue_rs1] &&
                !((oFwS1_sel == FW_ME) && iLong_done && (iLong_rd == iIssue_rs1));
  assign raw2 = (iIssue_rs2 != '0) && oPending[iIssue_rs2] &&
                !((oFwS2_sel == FW_ME) && iLong_done && (iLong_rd == iIssue_rs2));
  assign waw  = iIssue_long && oPending[iIssue_rd];
  assign strc = iIssue_long && (oLongCnt == LCNT_W'(MAX_LONG)) && !iLong_done;

  assign mem_stall = iStall_IF | iStall_ME;
  assign hz_stall  = raw1 | raw2 | waw | strc;
  assign br_flush  = !mem_stall && (iBrTrue || br_pend);

  always_comb begin
    stall_v = '0;
    flush_v = '0;
    if (hz_stall) begin
      stall_v[STG_ID:STG_IF] = '1;
      flush_v[STG_EX]        = 1'b1;
    end
    if (br_flush) begin
      stall_v[FRONT_STAGES-1:0] = '0;
      flush_v[FRONT_STAGES-1:0] = '1;
    end
    if (state == HZ_DRAIN) stall_v[STG_IF] = 1'b1;
    if (state == HZ_HALT)  stall_v = '1;
    if (mem_stall) begin
      stall_v = '1;
      flush_v = '0;
    end
  end

  assign oStall  = nRst ? stall_v : '0;
  assign oFlush  = nRst ? flush_v : '1;
  assign oHalted = (state == HZ_HALT);

  // Wrong-path (flushed) or held instructions must not claim a destination.
  assign accept = iIssue_valid && !hz_stall && !mem_stall && (state != HZ_HALT) && !br_flush;
  assign set_en = accept && iIssue_long && (iIssue_rd != '0);

  hz_scoreboard_regs #(
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW),
    .MAX_LONG (MAX_LONG),
    .LCNT_W   (LCNT_W)
  ) u_regs (
    .clk      (iClk),
    .rst_n    (nRst),
    .set_en   (set_en),
    .set_idx  (iIssue_rd),
    .clr_req  (iLong_done),
    .clr_idx  (iLong_rd),
    .pending  (oPending),
    .long_cnt (oLongCnt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      HZ_RUN:   if (iStall_dbg) state_nxt = HZ_DRAIN;
      HZ_DRAIN: if (!iStall_dbg) state_nxt = HZ_RUN;
                else if ((oLongCnt == '0) && !mem_stall) state_nxt = HZ_HALT;
      HZ_HALT:  if (!iStall_dbg) state_nxt = HZ_RUN;
      default:  state_nxt = HZ_RUN;
    endcase
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state        <= HZ_RUN;
      br_pend      <= 1'b0;
      oStallCycles <= '0;
    end else begin
      state   <= state_nxt;
      br_pend <= mem_stall ? (br_pend | iBrTrue) : 1'b0;
      if (oStall[STG_IF] && (oStallCycles != '1))
        oStallCycles <= oStallCycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expected values are queued as stimulus
// is driven and popped in order when the outputs are sampled.
module tb_hazard_scoreboard;
  import pipeline_types::*;

  logic        iClk, nRst;
  logic        iIssue_valid, iIssue_long;
  logic [4:0]  iIssue_rs1, iIssue_rs2, iIssue_rd;
  logic [4:0]  iEx_rd, iMe_rd, iLong_rd;
  logic        iEx_wen, iMe_wen, iLong_done;
  logic        iBrTrue, iStall_IF, iStall_ME, iStall_dbg;
  logic [3:0]  oStall, oFlush;
  fw_sel_t     oFwS1_sel, oFwS2_sel;
  logic [31:0] oPending;
  logic [2:0]  oLongCnt;
  logic        oHalted;
  logic [31:0] oStallCycles;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fails  = 0;
  logic [4:0] done_list[4] = '{5'd2, 5'd3, 5'd4, 5'd8};

  hazard_scoreboard dut (
    .iClk         (iClk),
    .nRst         (nRst),
    .iIssue_valid (iIssue_valid),
    .iIssue_rs1   (iIssue_rs1),
    .iIssue_rs2   (iIssue_rs2),
    .iIssue_rd    (iIssue_rd),
    .iIssue_long  (iIssue_long),
    .iEx_rd       (iEx_rd),
    .iEx_wen      (iEx_wen),
    .iMe_rd       (iMe_rd),
    .iMe_wen      (iMe_wen),
    .iLong_done   (iLong_done),
    .iLong_rd     (iLong_rd),
    .iBrTrue      (iBrTrue),
    .iStall_IF    (iStall_IF),
    .iStall_ME    (iStall_ME),
    .iStall_dbg   (iStall_dbg),
    .oStall       (oStall),
    .oFlush       (oFlush),
    .oFwS1_sel    (oFwS1_sel),
    .oFwS2_sel    (oFwS2_sel),
    .oPending     (oPending),
    .oLongCnt     (oLongCnt),
    .oHalted      (oHalted),
    .oStallCycles (oStallCycles)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected $finish");
    $fatal(1, "bench timed out");
  end

  task automatic push_exp(input string tag, input logic [63:0] val);
    sb_q.push_back('{tag, val});
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fails++;
      $error("FAIL sb_empty: observed %0h with no expected value queued", obs);
      return;
    end
    e = sb_q.pop_front();
    assert (obs === e.val)
      else begin
        n_fails++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
  endtask

  task automatic idle();
    iIssue_valid = 1'b0; iIssue_long = 1'b0;
    iIssue_rs1 = '0; iIssue_rs2 = '0; iIssue_rd = '0;
    iEx_rd = '0; iEx_wen = 1'b0; iMe_rd = '0; iMe_wen = 1'b0;
    iLong_done = 1'b0; iLong_rd = '0;
    iBrTrue = 1'b0; iStall_IF = 1'b0; iStall_ME = 1'b0; iStall_dbg = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 4 later.
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  initial begin
    nRst = 1'b0;
    idle();
    #3;
    push_exp("rst_stall", 64'h0);   push_exp("rst_flush", 64'hF);
    push_exp("rst_fw1", 64'(FW_NONE)); push_exp("rst_halted", 64'h0);
    push_exp("rst_pending", 64'h0); push_exp("rst_cnt", 64'h0);
    push_exp("rst_cycles", 64'h0);
    check(64'(oStall)); check(64'(oFlush)); check(64'(oFwS1_sel)); check(64'(oHalted));
    check(64'(oPending)); check(64'(oLongCnt)); check(64'(oStallCycles));
    tick(); tick();
    nRst = 1'b1;

    // Load to x5, then a dependent instruction waits for its completion.
    iIssue_valid = 1'b1; iIssue_long = 1'b1; iIssue_rd = 5'd5;
    push_exp("ld_issue_stall", 64'h0); push_exp("ld_issue_flush", 64'h0);
    #4; check(64'(oStall)); check(64'(oFlush));
    tick(); idle();
    iIssue_valid = 1'b1; iIssue_rs1 = 5'd5; iIssue_rd = 5'd6;
    push_exp("raw_stall_a", 64'h3); push_exp("raw_flush_a", 64'h4);
    push_exp("raw_pending", 64'h20); push_exp("raw_cnt", 64'h1);
    #4; check(64'(oStall)); check(64'(oFlush)); check(64'(oPending)); check(64'(oLongCnt));
    tick();
    push_exp("raw_stall_b", 64'h3); push_exp("raw_flush_b", 64'h4); push_exp("raw_cycles_b", 64'h1);
    #4; check(64'(oStall)); check(64'(oFlush)); check(64'(oStallCycles));
    tick();
    iLong_done = 1'b1; iLong_rd = 5'd5; iMe_rd = 5'd5; iMe_wen = 1'b1;
    push_exp("raw_done_fw1", 64'(FW_ME)); push_exp("raw_done_stall", 64'h0);
    push_exp("raw_done_flush", 64'h0); push_exp("raw_done_cycles", 64'h2);
    #4; check(64'(oFwS1_sel)); check(64'(oStall)); check(64'(oFlush)); check(64'(oStallCycles));
    tick(); idle();
    push_exp("raw_after_pending", 64'h0); push_exp("raw_after_cnt", 64'h0);
    #4; check(64'(oPending)); check(64'(oLongCnt));

    // Forwarding priority and per-source addressing.
    tick(); idle();
    iIssue_valid = 1'b1; iIssue_rs2 = 5'd3; iEx_rd = 5'd3; iEx_wen = 1'b1; iMe_rd = 5'd3; iMe_wen = 1'b1;
    push_exp("fw_ex_wins", 64'(FW_EX)); push_exp("fw_rs1_x0", 64'(FW_NONE));
    #4; check(64'(oFwS2_sel)); check(64'(oFwS1_sel));
    tick();
    iEx_wen = 1'b0;
    push_exp("fw_me_only", 64'(FW_ME));
    #4; check(64'(oFwS2_sel));
    tick();
    iIssue_rs1 = 5'd4; iEx_wen = 1'b1; iMe_rd = 5'd4;
    push_exp("fw_split_rs1", 64'(FW_ME)); push_exp("fw_split_rs2", 64'(FW_EX));
    #4; check(64'(oFwS1_sel)); check(64'(oFwS2_sel));
    tick(); idle();
    iIssue_valid = 1'b1; iEx_rd = 5'd0; iEx_wen = 1'b1; iMe_wen = 1'b1;
    push_exp("fw_x0_rs1", 64'(FW_NONE)); push_exp("fw_x0_rs2", 64'(FW_NONE));
    #4; check(64'(oFwS1_sel)); check(64'(oFwS2_sel));

    // Fill all long-op slots, then a fifth long issue.
    for (int i = 1; i <= 4; i++) begin
      tick(); idle();
      iIssue_valid = 1'b1; iIssue_long = 1'b1; iIssue_rd = 5'(i);
      push_exp("fill_stall", 64'h0);
      #4; check(64'(oStall));
    end
    tick(); idle();
    iIssue_valid = 1'b1; iIssue_long = 1'b1; iIssue_rd = 5'd8;
    push_exp("full_cnt", 64'h4); push_exp("full_pending", 64'h1E); push_exp("full_stall", 64'h3);
    #4; check(64'(oLongCnt)); check(64'(oPending)); check(64'(oStall));
    tick();
    iLong_done = 1'b1; iLong_rd = 5'd1;
    push_exp("full_done_stall", 64'h0); push_exp("full_done_cnt", 64'h4);
    #4; check(64'(oStall)); check(64'(oLongCnt));
    tick(); idle();
    push_exp("swap_cnt", 64'h4); push_exp("swap_pending", 64'h11C); push_exp("swap_cycles", 64'h3);
    #4; check(64'(oLongCnt)); check(64'(oPending)); check(64'(oStallCycles));
    for (int i = 0; i < 4; i++) begin
      tick(); idle();
      iLong_done = 1'b1; iLong_rd = done_list[i];
    end
    tick(); idle();
    push_exp("drain_cnt", 64'h0); push_exp("drain_pending", 64'h0);
    #4; check(64'(oLongCnt)); check(64'(oPending));

    // Branch taken during a 3-cycle memory stall flushes on the first free cycle.
    tick(); idle();
    iStall_ME = 1'b1; iBrTrue = 1'b1;
    push_exp("memst1_stall", 64'hF); push_exp("memst1_flush", 64'h0);
    #4; check(64'(oStall)); check(64'(oFlush));
    for (int i = 2; i <= 3; i++) begin
      tick(); idle();
      iStall_ME = 1'b1;
      push_exp("memst_stall", 64'hF); push_exp("memst_flush", 64'h0);
      #4; check(64'(oStall)); check(64'(oFlush));
    end
    tick(); idle();
    push_exp("late_flush", 64'h3); push_exp("late_stall", 64'h0);
    #4; check(64'(oFlush)); check(64'(oStall));
    tick();
    push_exp("late_flush_once", 64'h0); push_exp("memst_cycles", 64'h6);
    #4; check(64'(oFlush)); check(64'(oStallCycles));
    tick();
    iBrTrue = 1'b1;
    push_exp("br_direct_flush", 64'h3);
    #4; check(64'(oFlush));

    // Debug halt with two long ops outstanding.
    tick(); idle();
    iIssue_valid = 1'b1; iIssue_long = 1'b1; iIssue_rd = 5'd9;
    tick();
    iIssue_rd = 5'd10;
    tick(); idle();
    iStall_dbg = 1'b1;
    push_exp("dbg_req_stall", 64'h0); push_exp("dbg_req_cnt", 64'h2);
    #4; check(64'(oStall)); check(64'(oLongCnt));
    tick();
    iLong_done = 1'b1; iLong_rd = 5'd9;
    push_exp("drain1_stall", 64'h1); push_exp("drain1_halted", 64'h0);
    #4; check(64'(oStall)); check(64'(oHalted));
    tick();
    iLong_rd = 5'd10;
    push_exp("drain2_stall", 64'h1);
    #4; check(64'(oStall));
    tick();
    iLong_done = 1'b0;
    push_exp("drain3_stall", 64'h1); push_exp("drain3_cnt", 64'h0); push_exp("drain3_halted", 64'h0);
    #4; check(64'(oStall)); check(64'(oLongCnt)); check(64'(oHalted));
    tick();
    push_exp("halt_stall", 64'hF); push_exp("halt_halted", 64'h1);
    #4; check(64'(oStall)); check(64'(oHalted));
    tick();
    iStall_dbg = 1'b0;
    push_exp("release_halted", 64'h1);
    #4; check(64'(oHalted));
    tick();
    push_exp("run_halted", 64'h0); push_exp("run_stall", 64'h0); push_exp("dbg_cycles", 64'hB);
    #4; check(64'(oHalted)); check(64'(oStall)); check(64'(oStallCycles));

    // Asynchronous reset in the middle of a RAW stall on x7.
    tick(); idle();
    iIssue_valid = 1'b1; iIssue_long = 1'b1; iIssue_rd = 5'd7;
    tick(); idle();
    iIssue_valid = 1'b1; iIssue_rs1 = 5'd7; iIssue_rd = 5'd11;
    push_exp("x7_stall", 64'h3); push_exp("x7_pending", 64'h80);
    #4; check(64'(oStall)); check(64'(oPending));
    #1; nRst = 1'b0;
    #1;
    push_exp("arst_pending", 64'h0); push_exp("arst_cnt", 64'h0); push_exp("arst_cycles", 64'h0);
    push_exp("arst_stall", 64'h0); push_exp("arst_flush", 64'hF);
    check(64'(oPending)); check(64'(oLongCnt)); check(64'(oStallCycles));
    check(64'(oStall)); check(64'(oFlush));
    idle();
    tick();
    nRst = 1'b1;
    tick();
    push_exp("post_rst_pending", 64'h0); push_exp("post_rst_flush", 64'h0);
    #4; check(64'(oPending)); check(64'(oFlush));

    n_checks++;
    assert (sb_q.size() == 0)
      else begin
        n_fails++;
        $error("FAIL sb_leftover: observed %0d entries, expected 0", sb_q.size());
      end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
